// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if: control inputs and status outputs of clock_period_meter
//   enable_i, bit_i          : driven by master (stimulus side)
//   period_o, high_o, valid_o, edges_o, overflow_o : driven by slave (the meter)
interface clock_period_meter_if #(parameter int W = 32);
  logic         enable_i;
  logic         bit_i;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         valid_o;
  logic [W-1:0] edges_o;
  logic         overflow_o;
  modport master (output enable_i, bit_i, input period_o, high_o, valid_o, edges_o, overflow_o);
  modport slave (input enable_i, bit_i, output period_o, high_o, valid_o, edges_o, overflow_o);
endinterface

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of bit_i in clk_i cycles
//   clk_i     : system clock
//   reset_n_i : asynchronous active-low reset
//   bus       : slave side of clock_period_meter_if (enable/bit in, results out)
module clock_period_meter #(parameter int W = 32) (
  input  logic clk_i,
  input  logic reset_n_i,
  clock_period_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);
  state_t state, state_n;
  logic bit_d, rise, valid_n, overflow_n;
  logic [W-1:0] cnt, hcnt, cnt_n, hcnt_n, period_n, high_n, edges_n;
  assign rise = bus.bit_i & ~bit_d;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hcnt_n = hcnt;
    period_n = bus.period_o;
    high_n = bus.high_o;
    edges_n = bus.edges_o;
    overflow_n = bus.overflow_o;
    valid_n = 1'b0;
    if (!bus.enable_i) begin
      state_n = IDLE;
      cnt_n = '0;
      hcnt_n = '0;
    end else if (state == IDLE) begin
      state_n = ARM;
      edges_n = '0;
      overflow_n = 1'b0;
    end else if (rise) begin
      // the rise cycle itself is the first cycle (and first high cycle) of the new period
      state_n = MEASURE;
      cnt_n = ONE;
      hcnt_n = ONE;
      edges_n = bus.edges_o + ONE;
      period_n = (state == MEASURE) ? cnt : bus.period_o;
      high_n = (state == MEASURE) ? hcnt : bus.high_o;
      valid_n = (state == MEASURE);
    end else if (state == MEASURE) begin
      cnt_n = (cnt == MAX) ? cnt : cnt + ONE;
      hcnt_n = (bus.bit_i && hcnt != MAX) ? hcnt + ONE : hcnt;
      overflow_n = bus.overflow_o | (cnt_n == MAX);
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      bit_d <= 1'b0;
      cnt <= '0;
      hcnt <= '0;
      bus.period_o <= '0;
      bus.high_o <= '0;
      bus.valid_o <= 1'b0;
      bus.edges_o <= '0;
      bus.overflow_o <= 1'b0;
    end else begin
      state <= state_n;
      bit_d <= bus.bit_i;
      cnt <= cnt_n;
      hcnt <= hcnt_n;
      bus.period_o <= period_n;
      bus.high_o <= high_n;
      bus.valid_o <= valid_n;
      bus.edges_o <= edges_n;
      bus.overflow_o <= overflow_n;
    end
  end
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed table-driven check of clock_period_meter at W = 8
module tb_clock_period_meter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  clock_period_meter_if #(.W(8)) bus();
  clock_period_meter #(.W(8)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic en;
    int   p;
    int   h;
    logic v;
    int   ep;
    int   eh;
    int   ee;
  } row_t;
  row_t rows [17];
  task automatic cyc(input logic e, input logic b);
    @(negedge clk);
    bus.enable_i = e;
    bus.bit_i = b;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic v, input int p, input int h, input int e, input logic o);
    chk({nm, ".valid"}, 32'(bus.valid_o), 32'(v));
    chk({nm, ".period"}, 32'(bus.period_o), p);
    chk({nm, ".high"}, 32'(bus.high_o), h);
    chk({nm, ".edges"}, 32'(bus.edges_o), e);
    chk({nm, ".overflow"}, 32'(bus.overflow_o), 32'(o));
  endtask
  initial begin
    // each row is one wave period: H cycles high then P-H low; checks after its first cycle
    rows = '{
      '{1'b1,  1, 0, 1'b0,  0, 0,  0},
      '{1'b1, 10, 5, 1'b0,  0, 0,  1},
      '{1'b1, 10, 5, 1'b1, 10, 5,  2},
      '{1'b1, 10, 5, 1'b1, 10, 5,  3},
      '{1'b1, 10, 5, 1'b1, 10, 5,  4},
      '{1'b1,  7, 5, 1'b1, 10, 5,  5},
      '{1'b1,  4, 1, 1'b1,  7, 5,  6},
      '{1'b1,  4, 1, 1'b1,  4, 1,  7},
      '{1'b1,  4, 1, 1'b1,  4, 1,  8},
      '{1'b1,  2, 1, 1'b1,  4, 1,  9},
      '{1'b1,  2, 1, 1'b1,  2, 1, 10},
      '{1'b1,  2, 1, 1'b1,  2, 1, 11},
      '{1'b1,  4, 1, 1'b1,  2, 1, 12},
      '{1'b0,  3, 1, 1'b0,  2, 1, 12},
      '{1'b1,  1, 0, 1'b0,  2, 1,  0},
      '{1'b1,  4, 1, 1'b0,  2, 1,  1},
      '{1'b1,  4, 1, 1'b1,  4, 1,  2}
    };
    bus.enable_i = 1'b0;
    bus.bit_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc(i[0], ~i[0]);
    chk_all("in_reset", 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable_i = 1'b0;
    bus.bit_i = 1'b0;
    for (int r = 0; r < 17; r++) begin
      for (int c = 0; c < rows[r].p; c++) begin
        cyc(rows[r].en, c < rows[r].h);
        if (c == 0) chk_all($sformatf("row%0d", r), rows[r].v, rows[r].ep, rows[r].eh, rows[r].ee, 1'b0);
        else chk($sformatf("row%0d.valid_c%0d", r, c), 32'(bus.valid_o), 0);
      end
    end
    for (int k = 1; k <= 251; k++) begin
      cyc(1'b1, 1'b0);
      if (k == 250) chk("ovf_before", 32'(bus.overflow_o), 0);
      if (k == 251) chk("ovf_at_255", 32'(bus.overflow_o), 1);
      if (k == 200) chk("stuck_no_valid", 32'(bus.valid_o), 0);
    end
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk_all("sat_rise", 1'b1, 255, 1, 3, 1'b1);
    cyc(1'b1, 1'b0);
    chk_all("sat_after", 1'b0, 255, 1, 3, 1'b1);
    cyc(1'b0, 1'b0);
    chk_all("idle_hold", 1'b0, 255, 1, 3, 1'b1);
    cyc(1'b1, 1'b0);
    chk_all("rearm_clear", 1'b0, 255, 1, 0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
    end
    chk_all("wrap300", 1'b0, 3, 1, 44, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 1'b0, 0, 0, 0, 1'b0);
    #5 rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
